mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 mem_data_i, mem_wd_i, mem_wreg_i  in  32/5/1  ALU result, destination register, write enable, from the EX/MEM register.
REQ-004 mem_lsop_i  in  4  load/store op: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9-15 treated as none.
REQ-005 mem_memaddr_i, mem_reg2_i  in  32/32  effective address and store source data.
REQ-006 mem_delay_i  in  1  instruction is in a delay slot.
REQ-007 wb_stall_i  in  1  MEM/WB register is stalled (stall[4]).
REQ-008 bus_req, bus_we  out  1/1  data-bus request (registered) and write strobe.
REQ-009 bus_addr, bus_wdata  out  32/32  word-aligned address ({addr[31:2],2'b00}) and lane-replicated store data.
REQ-010 bus_sel  out  4  byte-lane enables; bit n = byte n, little-endian.
REQ-011 bus_ack, bus_rdata  in  1/32  single-cycle completion pulse and read word.
REQ-012 stallreq_o  out  1  stall request to the pipeline stall controller.
REQ-013 wb_wdata_o, wb_wd_o, wb_wreg_o  out  32/5/1  write-back data, destination register, write enable, to MEM/WB.
REQ-014 wb_delay_o  out  1  mem_delay_i passed through.
REQ-015 exc_align_o  out  1  misaligned-access flag.

Function
REQ-016 FSM states: IDLE, BUSY, DONE.
REQ-017 Aligned means: halfword ops need addr[0]=0, word ops need addr[1:0]=0, byte ops are always aligned.
REQ-018 IDLE, op none: stallreq_o=0; wb_wdata_o=mem_data_i, wb_wd_o=mem_wd_i, wb_wreg_o=mem_wreg_i; stay in IDLE.
REQ-019 IDLE, op misaligned: exc_align_o=1, wb_wreg_o=0, stallreq_o=0, no bus request; stay in IDLE.
REQ-020 IDLE, op aligned: stallreq_o=1 in the same cycle; next edge bus_req<=1, bus_we/addr/wdata/sel registered from the inputs; go to BUSY.
REQ-021 BUSY: stallreq_o=1; bus_req and the bus fields are held stable until bus_ack=1.
REQ-022 BUSY with bus_ack=1: that edge clears bus_req, latches bus_rdata (loads), and goes to DONE; bus_ack has no effect in IDLE or DONE.
REQ-023 DONE: stallreq_o=0.
REQ-024 DONE, load: wb_wdata_o = extended latched data, wb_wreg_o = mem_wreg_i.
REQ-025 DONE, store: wb_wdata_o = mem_data_i, wb_wreg_o = mem_wreg_i.
REQ-026 DONE with wb_stall_i=1: stay in DONE; otherwise go to IDLE on the next edge.
REQ-027 Minimum memory-op latency: 3 cycles (IDLE, BUSY with ack in its first cycle, DONE); each extra BUSY cycle adds one.
REQ-028 Byte select: lane = addr[1:0]; halfword select: lane pair = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-029 Stores: SB bus_wdata = {4{reg2[7:0]}}, bus_sel = 1<<addr[1:0]; SH bus_wdata = {2{reg2[15:0]}}, bus_sel = 4'b0011 or 4'b1100; SW bus_sel = 4'b1111.
REQ-030 Loads: bus_we=0 and bus_sel per the access size.
REQ-031 exc_align_o is combinational and 0 in BUSY and DONE.
REQ-032 wb_wd_o and wb_delay_o always follow the inputs combinationally.

Reset
REQ-033 rst=1 asynchronously forces: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, latched read data=0.
REQ-034 While rst=1: stallreq_o=0, wb_wreg_o=0, exc_align_o=0.
REQ-035 Reset asserted mid-BUSY abandons the access: bus_req drops immediately, and a later bus_ack is ignored.
REQ-036 After reset release, the FSM starts from IDLE at the next rising edge.

Verification
REQ-037 LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> stallreq high 3 cycles; DONE gives wb_wdata_o=0xDEADBEEF, wb_wreg_o=1.
REQ-038 LB addr 0x103, rdata 0x80112233 -> wb_wdata_o=0xFFFFFF80. LBU same inputs -> wb_wdata_o=0x00000080.
REQ-039 SH addr 0x202, reg2 0x0000ABCD -> bus_we=1, bus_sel=4'b1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
REQ-040 LW addr 0x101 -> exc_align_o=1, wb_wreg_o=0, bus_req never asserted, stallreq_o=0.
REQ-041 DONE with wb_stall_i=1 for 3 cycles -> state held, wb_wdata_o stable, and no second bus request.
REQ-042 rst pulsed during BUSY, then bus_ack=1 -> bus_req=0 at once, state IDLE, and the ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//   Takes the EX/MEM register outputs, runs load/store accesses over a
//   simple request/ack data bus, and presents write-back values to MEM/WB.
// Ports:
//   clk, rst                          clock, async active-high reset
//   mem_data_i/mem_wd_i/mem_wreg_i    ALU result, dest reg, write enable
//   mem_lsop_i                        load/store opcode (0 none, 1..8 ops)
//   mem_memaddr_i, mem_reg2_i         effective address, store source data
//   mem_delay_i                       delay-slot flag (passed through)
//   wb_stall_i                        MEM/WB register stalled
//   bus_req/bus_we/bus_addr/bus_wdata/bus_sel   registered bus request
//   bus_ack, bus_rdata                completion pulse and read word
//   stallreq_o                        pipeline stall request
//   wb_wdata_o/wb_wd_o/wb_wreg_o      write-back data, dest reg, enable
//   wb_delay_o                        delay-slot flag to MEM/WB
//   exc_align_o                       misaligned-access flag
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [3:0]  mem_lsop_i,
  input  logic [31:0] mem_memaddr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic        mem_delay_i,
  input  logic        wb_stall_i,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq_o,
  output logic [31:0] wb_wdata_o,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic        wb_delay_o,
  output logic        exc_align_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } lsop_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;

  // Opcode decode of the incoming instruction
  logic is_load, is_store, is_mem;
  logic sz_byte, sz_half, sz_word;
  logic misaligned;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    case (mem_lsop_i)
      OP_LB, OP_LBU: begin is_load  = 1'b1; sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
      default:       ;
    endcase
    is_mem     = is_load | is_store;
    misaligned = (sz_half & mem_memaddr_i[0]) |
                 (sz_word & (mem_memaddr_i[1:0] != 2'b00));
  end

  // Byte-lane enables and lane-replicated store data for the request
  always_comb begin
    req_sel   = '0;
    req_wdata = '0;
    if (sz_byte) begin
      req_sel = 4'b0001 << mem_memaddr_i[1:0];
    end else if (sz_half) begin
      req_sel = mem_memaddr_i[1] ? 4'b1100 : 4'b0011;
    end else if (sz_word) begin
      req_sel = 4'b1111;
    end
    if (is_store) begin
      if (sz_byte)      req_wdata = {4{mem_reg2_i[7:0]}};
      else if (sz_half) req_wdata = {2{mem_reg2_i[15:0]}};
      else              req_wdata = mem_reg2_i;
    end
  end

  // Next-state and bus register update
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    rdata_d     = rdata_q;
    op_d        = op_q;
    lane_d      = lane_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem && !misaligned) begin
          state_d     = S_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = is_store;
          bus_addr_d  = {mem_memaddr_i[31:2], 2'b00};
          bus_wdata_d = req_wdata;
          bus_sel_d   = req_sel;
          // Op and lane are kept so DONE extends the data of the access
          // actually issued, independent of the EX/MEM inputs.
          op_d        = mem_lsop_i;
          lane_d      = mem_memaddr_i[1:0];
        end
      end
      S_BUSY: begin
        if (bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          if (op_q >= OP_LB && op_q <= OP_LW) rdata_d = bus_rdata;
        end
      end
      S_DONE: begin
        if (!wb_stall_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
      rdata_q     <= '0;
      op_q        <= '0;
      lane_q      <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
      rdata_q     <= rdata_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;

  // Extension of the latched read word for the issued load
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (op_q)
      OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_ext = {24'd0, ld_byte};
      OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  // Stage outputs; write enable is suppressed while an access is pending
  always_comb begin
    stallreq_o  = 1'b0;
    exc_align_o = 1'b0;
    wb_wdata_o  = mem_data_i;
    wb_wreg_o   = mem_wreg_i;
    if (rst) begin
      wb_wreg_o = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mem) begin
            wb_wreg_o = 1'b0;
            if (misaligned) exc_align_o = 1'b1;
            else            stallreq_o  = 1'b1;
          end
        end
        S_BUSY: begin
          stallreq_o = 1'b1;
          wb_wreg_o  = 1'b0;
        end
        S_DONE: begin
          if (op_q >= OP_LB && op_q <= OP_LW) wb_wdata_o = ld_ext;
        end
        default: ;
      endcase
    end
  end

  assign wb_wd_o    = mem_wd_i;
  assign wb_delay_o = mem_delay_i;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized plus directed checks of mem_stage against a
//   behavioural model of the load/store rules (sizes, lanes, extension,
//   alignment) and the IDLE/BUSY/DONE handshake timing.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_data_i;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [3:0]  mem_lsop_i;
  logic [31:0] mem_memaddr_i;
  logic [31:0] mem_reg2_i;
  logic        mem_delay_i;
  logic        wb_stall_i;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq_o;
  logic [31:0] wb_wdata_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o, wb_delay_o, exc_align_o;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .mem_data_i(mem_data_i), .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i),
    .mem_lsop_i(mem_lsop_i), .mem_memaddr_i(mem_memaddr_i),
    .mem_reg2_i(mem_reg2_i), .mem_delay_i(mem_delay_i),
    .wb_stall_i(wb_stall_i),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq_o(stallreq_o), .wb_wdata_o(wb_wdata_o), .wb_wd_o(wb_wd_o),
    .wb_wreg_o(wb_wreg_o), .wb_delay_o(wb_delay_o), .exc_align_o(exc_align_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int m_size(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_load(input int op);
    return op >= 1 && op <= 5;
  endfunction

  function automatic bit m_aligned(input int op, input logic [31:0] addr);
    return (addr % m_size(op)) == 0;
  endfunction

  function automatic logic [3:0] m_sel(input int op, input logic [31:0] addr);
    int sz = m_size(op);
    int off = int'(addr % 4) / sz * sz;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] reg2);
    int sz = m_size(op);
    longint unsigned mask = (64'd1 << (8 * sz)) - 1;
    longint unsigned v = reg2 & mask;
    longint unsigned w = 0;
    for (int k = 0; k < 4; k += sz) w = w | (v << (8 * k));
    return w[31:0];
  endfunction

  function automatic logic [31:0] m_ldval(input int op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
    int sz = m_size(op);
    longint unsigned mask = (64'd1 << (8 * sz)) - 1;
    longint unsigned v = rdata;
    v = (v >> (8 * (addr % 4))) & mask;
    if ((op == 1 || op == 3) && v >= (mask + 1) / 2)
      v = v | (64'hFFFF_FFFF & ~mask);
    return v[31:0];
  endfunction

  // Runs one instruction starting at a negedge with the stage in IDLE.
  // delay = BUSY cycles before the ack cycle; nstall = DONE cycles held.
  task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] rdata, input int delay, input int nstall);
    logic [31:0] data, exp_wb;
    logic        wreg;
    int          stall_cnt;
    data = $urandom;
    wreg = 1'($urandom);
    mem_lsop_i    = 4'(op);
    mem_memaddr_i = addr;
    mem_reg2_i    = reg2;
    mem_data_i    = data;
    mem_wreg_i    = wreg;
    mem_wd_i      = 5'($urandom);
    mem_delay_i   = 1'($urandom);
    bus_ack       = 1'b0;
    #1;
    chk("wd_pass", 32'(wb_wd_o), 32'(mem_wd_i));
    chk("delay_pass", 32'(wb_delay_o), 32'(mem_delay_i));
    if (m_size(op) == 0) begin
      chk("none_stall", 32'(stallreq_o), 0);
      chk("none_exc", 32'(exc_align_o), 0);
      chk("none_wdata", wb_wdata_o, data);
      chk("none_wreg", 32'(wb_wreg_o), 32'(wreg));
      @(negedge clk);
      chk("none_req", 32'(bus_req), 0);
      return;
    end
    if (!m_aligned(op, addr)) begin
      chk("mis_exc", 32'(exc_align_o), 1);
      chk("mis_wreg", 32'(wb_wreg_o), 0);
      chk("mis_stall", 32'(stallreq_o), 0);
      @(negedge clk);
      #1;
      chk("mis_req", 32'(bus_req), 0);
      chk("mis_exc2", 32'(exc_align_o), 1);
      mem_lsop_i = 4'd0;
      @(negedge clk);
      return;
    end
    chk("idle_stall", 32'(stallreq_o), 1);
    chk("idle_req", 32'(bus_req), 0);
    stall_cnt = 1;
    for (int b = 0; b <= delay; b++) begin
      @(negedge clk);
      bus_ack   = (b == delay);
      bus_rdata = (b == delay) ? rdata : $urandom;
      #1;
      chk("busy_req", 32'(bus_req), 1);
      chk("busy_we", 32'(bus_we), m_load(op) ? 0 : 1);
      chk("busy_addr", bus_addr, {addr[31:2], 2'b00});
      chk("busy_sel", 32'(bus_sel), 32'(m_sel(op, addr)));
      if (!m_load(op)) chk("busy_wdata", bus_wdata, m_wdata(op, reg2));
      chk("busy_exc", 32'(exc_align_o), 0);
      stall_cnt += int'(stallreq_o);
    end
    exp_wb = m_load(op) ? m_ldval(op, addr, rdata) : data;
    @(negedge clk);
    bus_ack   = 1'b0;
    bus_rdata = $urandom;
    #1;
    stall_cnt += int'(stallreq_o);
    chk("stall_cycles", 32'(stall_cnt), 32'(delay + 2));
    chk("done_req", 32'(bus_req), 0);
    chk("done_exc", 32'(exc_align_o), 0);
    chk("done_wdata", wb_wdata_o, exp_wb);
    chk("done_wreg", 32'(wb_wreg_o), 32'(wreg));
    wb_stall_i = (nstall > 0);
    bus_ack    = (nstall > 0) ? 1'($urandom) : 1'b0;
    for (int s = 0; s < nstall; s++) begin
      @(negedge clk);
      wb_stall_i = (s + 1 < nstall);
      bus_ack    = 1'($urandom);
      #1;
      chk("hold_stall", 32'(stallreq_o), 0);
      chk("hold_req", 32'(bus_req), 0);
      chk("hold_wdata", wb_wdata_o, exp_wb);
    end
    @(negedge clk);
    bus_ack    = 1'b0;
    mem_lsop_i = 4'd0;
    mem_data_i = ~data;
    #1;
    chk("back_idle_wdata", wb_wdata_o, ~data);
    chk("back_idle_req", 32'(bus_req), 0);
  endtask

  task automatic reset_mid_busy();
    mem_lsop_i    = 4'd5;
    mem_memaddr_i = 32'h0000_0400;
    mem_data_i    = 32'h1234_5678;
    bus_ack       = 1'b0;
    @(negedge clk);
    #1;
    chk("rb_req_before", 32'(bus_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("rb_req_drop", 32'(bus_req), 0);
    chk("rb_addr", bus_addr, 0);
    chk("rb_sel", 32'(bus_sel), 0);
    chk("rb_stall", 32'(stallreq_o), 0);
    chk("rb_wreg", 32'(wb_wreg_o), 0);
    @(negedge clk);
    rst        = 1'b0;
    mem_lsop_i = 4'd0;
    bus_ack    = 1'b1;
    bus_rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("rb_ack_ignored", 32'(bus_req), 0);
    chk("rb_idle_stall", 32'(stallreq_o), 0);
    chk("rb_idle_wdata", wb_wdata_o, 32'h1234_5678);
  endtask

  initial begin
    rst = 1'b1;
    mem_data_i = '0; mem_wd_i = '0; mem_wreg_i = 1'b1; mem_lsop_i = 4'd5;
    mem_memaddr_i = '0; mem_reg2_i = '0; mem_delay_i = 1'b0;
    wb_stall_i = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #2;
    chk("rst_req", 32'(bus_req), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_sel", 32'(bus_sel), 0);
    chk("rst_stall", 32'(stallreq_o), 0);
    chk("rst_wreg", 32'(wb_wreg_o), 0);
    chk("rst_exc", 32'(exc_align_o), 0);
    @(negedge clk);
    rst = 1'b0;
    mem_lsop_i = 4'd0;
    @(negedge clk);

    // directed cases
    run_op(5, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1, 0);
    run_op(1, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0);
    run_op(2, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 0);
    run_op(7, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 0);
    run_op(5, 32'h0000_0101, 32'h0, 32'h0, 0, 0);
    run_op(3, 32'h0000_0102, 32'h0, 32'h8001_7FFF, 2, 3);
    run_op(0, 32'h0, 32'h0, 32'h0, 0, 0);
    run_op(12, 32'h0000_0003, 32'h0, 32'h0, 0, 0);
    reset_mid_busy();

    // randomized instructions
    for (int i = 0; i < 80; i++) begin
      run_op(int'($urandom_range(0, 9)), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
